// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(21,16) + overall-parity SECDED counter path.
// The counter-side encoder and hamming_secded_decoder both use these helpers.
package hamming_pkg;
    localparam int DATA_W = 16;
    localparam int CODE_W = 22;
    localparam int NPAR   = 5;

    typedef logic [CODE_W-1:0] code_t;

    // Hamming position of data bits d0..d15; power-of-two positions hold check bits
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

    function automatic logic [NPAR-1:0] calc_syndrome(input code_t code);
        logic [NPAR-1:0] syn;
        syn = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[NPAR'(i)]) syn = syn ^ NPAR'(i);
        end
        return syn;
    endfunction

    function automatic logic calc_parity(input code_t code);
        return ^code;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input code_t code);
        logic [DATA_W-1:0] data;
        data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data[4'(i)] = code[NPAR'(DATA_POS[i])];
        end
        return data;
    endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for one SECDED codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  code_t           code,
    output logic [NPAR-1:0] syn,
    output logic            par
);
    assign syn = calc_syndrome(code);
    assign par = calc_parity(code);
endmodule

// File: rtl/hamming_secded_decoder.sv
// SECDED decoder for the protected 16-bit counter path: two-stage valid/ready pipeline
// that corrects single-bit errors, flags double-bit errors and keeps saturating counts.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count
);
    code_t           s1_code;
    logic [NPAR-1:0] s1_syn;
    logic            s1_par;
    logic            v1;
    logic [NPAR-1:0] syn;
    logic            par;
    code_t           fixed_code;
    logic            dec_sec;
    logic            dec_ded;
    logic            load2;

    hamming_syndrome u_syndrome (
        .code (in_code),
        .syn  (syn),
        .par  (par)
    );

    assign load2    = !out_valid || out_ready;
    assign in_ready = !v1 || load2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            s1_code <= '0;
            s1_syn  <= '0;
            s1_par  <= 1'b0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= syn;
                s1_par  <= par;
            end
        end
    end

    // Syndrome 0 with bad parity flips bit 0, which carries no data, so it shares the fix path
    always_comb begin
        fixed_code = s1_code;
        dec_sec    = 1'b0;
        dec_ded    = 1'b0;
        if (s1_par) begin
            if (s1_syn <= NPAR'(CODE_W - 1)) begin
                dec_sec            = 1'b1;
                fixed_code[s1_syn] = ~s1_code[s1_syn];
            end else begin
                dec_ded = 1'b1;
            end
        end else if (s1_syn != '0) begin
            dec_ded = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sec   <= 1'b0;
            out_ded   <= 1'b0;
        end else if (load2) begin
            out_valid <= v1;
            if (v1) begin
                out_data <= extract_data(fixed_code);
                out_sec  <= dec_sec;
                out_ded  <= dec_ded;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (clr_cnt) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (out_valid && out_ready) begin
            if (out_sec && (sec_count != '1)) sec_count <= sec_count + CNT_W'(1);
            if (out_ded && (ded_count != '1)) ded_count <= ded_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder using hand-encoded codewords.
// Counters are 2 bits wide so saturation is reachable with a handful of words.
module tb_hamming_secded_decoder;
    localparam int CNT_W = 2;

    localparam logic [21:0] ENC_0000 = 22'h000000;
    localparam logic [21:0] ENC_A5A5 = 22'h28B45F;
    localparam logic [21:0] ENC_1234 = 22'h054742;
    localparam logic [21:0] ENC_FFFF = 22'h3FFFFC;
    localparam logic [21:0] ENC_00FF = 22'h001EEE;
    localparam logic [21:0] ENC_0001 = 22'h00000F;
    localparam logic [21:0] ENC_8000 = 22'h210012;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [21:0]      in_code = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic             out_sec;
    logic             out_ded;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;

    int checks = 0;
    int errors = 0;

    hamming_secded_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sec   (out_sec),
        .out_ded   (out_ded),
        .clr_cnt   (clr_cnt),
        .sec_count (sec_count),
        .ded_count (ded_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for a single cycle; returns when it sits in the output stage
    task automatic send_one(input logic [21:0] code);
        in_valid = 1'b1;
        in_code  = code;
        tick();
        in_valid = 1'b0;
        in_code  = '0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if ({out_valid, out_sec, out_ded} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {out_valid, out_sec, out_ded}); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", out_data); end
        checks++;
        if ({sec_count, ded_count} !== '0) begin errors++; $display("[TB] FAIL reset_counts: got sec=%0d ded=%0d expected 0 0", sec_count, ded_count); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = ENC_0000;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready); end
        tick();
        in_code = ENC_A5A5;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_early_valid: got %b expected 0", out_valid); end
        tick();
        in_valid = 1'b0;
        in_code  = '0;
        checks++;
        if ({out_valid, out_data, out_sec, out_ded} !== {1'b1, 16'h0000, 2'b00}) begin
            errors++; $display("[TB] FAIL b2b_word0: got v=%b d=%h sec=%b ded=%b expected v=1 d=0000 no flags", out_valid, out_data, out_sec, out_ded);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_sec, out_ded} !== {1'b1, 16'hA5A5, 2'b00}) begin
            errors++; $display("[TB] FAIL b2b_word1: got v=%b d=%h sec=%b ded=%b expected v=1 d=a5a5 no flags", out_valid, out_data, out_sec, out_ded);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", out_valid); end
        checks++;
        if ({sec_count, ded_count} !== '0) begin errors++; $display("[TB] FAIL b2b_counts: got sec=%0d ded=%0d expected 0 0", sec_count, ded_count); end
    endtask

    task automatic test_single_error();
        out_ready = 1'b1;
        send_one(ENC_A5A5 ^ 22'h000020);
        checks++;
        if ({out_valid, out_data, out_sec, out_ded} !== {1'b1, 16'hA5A5, 2'b10}) begin
            errors++; $display("[TB] FAIL sec_bit5: got v=%b d=%h sec=%b ded=%b expected v=1 d=a5a5 sec=1 ded=0", out_valid, out_data, out_sec, out_ded);
        end
        tick();
        checks++;
        if (sec_count !== 2'd1) begin errors++; $display("[TB] FAIL sec_count1: got %0d expected 1", sec_count); end
        send_one(ENC_A5A5 ^ 22'h000001);
        checks++;
        if ({out_valid, out_data, out_sec, out_ded} !== {1'b1, 16'hA5A5, 2'b10}) begin
            errors++; $display("[TB] FAIL sec_bit0: got v=%b d=%h sec=%b ded=%b expected v=1 d=a5a5 sec=1 ded=0", out_valid, out_data, out_sec, out_ded);
        end
        tick();
        checks++;
        if ({sec_count, ded_count} !== {2'd2, 2'd0}) begin errors++; $display("[TB] FAIL sec_count2: got sec=%0d ded=%0d expected 2 0", sec_count, ded_count); end
    endtask

    task automatic test_double_error();
        out_ready = 1'b1;
        send_one(ENC_1234 ^ 22'h000088);
        checks++;
        if ({out_valid, out_sec, out_ded} !== 3'b101) begin
            errors++; $display("[TB] FAIL ded_flags: got v=%b sec=%b ded=%b expected v=1 sec=0 ded=1", out_valid, out_sec, out_ded);
        end
        checks++;
        if (out_data !== 16'h123D) begin errors++; $display("[TB] FAIL ded_raw_data: got %h expected 123d", out_data); end
        tick();
        checks++;
        if ({sec_count, ded_count} !== {2'd2, 2'd1}) begin errors++; $display("[TB] FAIL ded_count: got sec=%0d ded=%0d expected 2 1", sec_count, ded_count); end
    endtask

    task automatic test_backpressure();
        logic [21:0] codes [6];
        logic [15:0] datas [6];
        int idx_in;
        int idx_out;
        int cyc;
        logic take_in;
        logic take_out;
        codes = '{ENC_FFFF, ENC_00FF, ENC_0001, ENC_8000, ENC_1234, ENC_A5A5};
        datas = '{16'hFFFF, 16'h00FF, 16'h0001, 16'h8000, 16'h1234, 16'hA5A5};
        idx_in  = 0;
        idx_out = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx_in < 6);
            in_code  = codes[idx_in];
            #1;
            take_in = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (out_data !== 16'hFFFF) begin errors++; $display("[TB] FAIL stall_hold: cycle %0d got %h expected ffff", c, out_data); end
            end
            tick();
            if (take_in) idx_in++;
        end
        #1;
        checks++;
        if (idx_in !== 2 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_accepts: got %0d accepts in_ready=%b expected 2 accepts in_ready=0", idx_in, in_ready);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (idx_out < 6 && cyc < 40) begin
            in_valid = (idx_in < 6);
            in_code  = (idx_in < 6) ? codes[idx_in] : '0;
            #1;
            take_in  = in_valid && in_ready;
            take_out = out_valid && out_ready;
            if (take_out) begin
                checks++;
                if ({out_data, out_sec, out_ded} !== {datas[idx_out], 2'b00}) begin
                    errors++; $display("[TB] FAIL release_word%0d: got d=%h sec=%b ded=%b expected d=%h no flags", idx_out, out_data, out_sec, out_ded, datas[idx_out]);
                end
                idx_out++;
            end
            tick();
            if (take_in) idx_in++;
            cyc++;
        end
        in_valid = 1'b0;
        in_code  = '0;
        checks++;
        if (idx_out !== 6) begin errors++; $display("[TB] FAIL release_timeout: got %0d words expected 6", idx_out); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_extra: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        int flips [5];
        flips = '{1, 2, 21, 13, 0};
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if ({sec_count, ded_count} !== '0) begin errors++; $display("[TB] FAIL clr_idle: got sec=%0d ded=%0d expected 0 0", sec_count, ded_count); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = ENC_A5A5 ^ (22'd1 << flips[i]);
            tick();
        end
        in_valid = 1'b0;
        in_code  = '0;
        repeat (3) tick();
        checks++;
        if (sec_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 3", sec_count); end
        send_one(ENC_A5A5 ^ 22'h000400);
        checks++;
        if ({out_valid, out_sec, sec_count} !== {2'b11, 2'd3}) begin
            errors++; $display("[TB] FAIL sat_sixth: got v=%b sec=%b count=%0d expected v=1 sec=1 count=3", out_valid, out_sec, sec_count);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if ({out_valid, sec_count} !== {1'b0, 2'd0}) begin
            errors++; $display("[TB] FAIL clr_priority: got v=%b count=%0d expected v=0 count=0", out_valid, sec_count);
        end
    endtask

    task automatic test_stall_clear();
        out_ready = 1'b1;
        send_one(ENC_1234 ^ 22'h000088);
        tick();
        checks++;
        if (ded_count !== 2'd1) begin errors++; $display("[TB] FAIL stallclr_pre: got ded=%0d expected 1", ded_count); end
        out_ready = 1'b0;
        send_one(ENC_00FF ^ 22'h000200);
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++;
        if ({out_valid, out_data, out_sec, sec_count, ded_count} !== {1'b1, 16'h00FF, 1'b1, 2'd0, 2'd0}) begin
            errors++; $display("[TB] FAIL stallclr_held: got v=%b d=%h sec=%b sc=%0d dc=%0d expected v=1 d=00ff sec=1 sc=0 dc=0", out_valid, out_data, out_sec, sec_count, ded_count);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, sec_count, ded_count} !== {1'b0, 2'd1, 2'd0}) begin
            errors++; $display("[TB] FAIL stallclr_release: got v=%b sc=%0d dc=%0d expected v=0 sc=1 dc=0", out_valid, sec_count, ded_count);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = ENC_8000;
        tick();
        in_code = ENC_0001;
        tick();
        in_valid = 1'b0;
        in_code  = '0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++; $display("[TB] FAIL rst_full: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sec_count, ded_count} !== {2'b10, 2'd0, 2'd0}) begin
            errors++; $display("[TB] FAIL rst_async: got in_ready=%b v=%b sc=%0d dc=%0d expected 1 0 0 0", in_ready, out_valid, sec_count, ded_count);
        end
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = ENC_FFFF;
        tick();
        in_valid = 1'b0;
        in_code  = '0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_early: got %b expected 0", out_valid); end
        tick();
        checks++;
        if ({out_valid, out_data, out_sec, out_ded} !== {1'b1, 16'hFFFF, 2'b00}) begin
            errors++; $display("[TB] FAIL rst_after_word: got v=%b d=%h sec=%b ded=%b expected v=1 d=ffff no flags", out_valid, out_data, out_sec, out_ded);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_drain: got %b expected 0", out_valid); end
    endtask

    initial begin
        $display("[TB] starting hamming_secded_decoder bench");
        test_reset();
        test_back_to_back();
        test_single_error();
        test_double_error();
        test_backpressure();
        test_saturation();
        test_stall_clear();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
